// File: rtl/counter_monitor.sv
// rtl/counter_monitor.sv - sequence checker for a free-running up-counter bus.
// Optional COUNTER_MONITOR_RESET_TOLERANT_EN: a 0 seen while LOCKED resyncs instead of faulting.
module counter_monitor #(
    parameter int WIDTH      = 8,
    parameter int STAT_WIDTH = 8,
    parameter int LOCK_LEN   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  count_valid,
    input  logic [WIDTH-1:0]      match_value,
    input  logic                  clear_err,
    output logic                  locked,
    output logic                  match_pulse,
    output logic                  wrap_pulse,
    output logic                  seq_err,
    output logic [STAT_WIDTH-1:0] wrap_count,
    output logic [STAT_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {ACQUIRE, SYNC, LOCKED, FAULT} state_t;

    localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0]      CNT_MAX  = '1;
    localparam logic [3:0]            RUN_ONE  = 4'd1;
    localparam logic [3:0]            RUN_LOCK = 4'(LOCK_LEN);
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    state_t                  state, state_next;
    logic [WIDTH-1:0]        prev, prev_next, prev_inc;
    logic [3:0]              run, run_next, run_inc;
    logic                    step_ok, step_wrap, fault;
    logic                    match_next, wrap_next, seq_err_next;
    logic [STAT_WIDTH-1:0]   wrap_count_next, err_count_next;

    assign prev_inc  = prev + CNT_ONE;
    assign run_inc   = run + RUN_ONE;
    assign step_ok   = (count_in == prev_inc);
    assign step_wrap = step_ok && (prev == CNT_MAX);
    assign locked    = (state == LOCKED);

    always_comb begin
        state_next      = state;
        prev_next       = prev;
        run_next        = run;
        match_next      = 1'b0;
        wrap_next       = 1'b0;
        fault           = 1'b0;
        seq_err_next    = seq_err;
        wrap_count_next = wrap_count;
        err_count_next  = err_count;

        if (count_valid) begin
            match_next = (count_in == match_value);
            prev_next  = count_in;
            case (state)
                ACQUIRE: begin
                    run_next   = '0;
                    state_next = SYNC;
                end
                SYNC: begin
                    if (step_ok) begin
                        run_next  = run_inc;
                        wrap_next = step_wrap;
                        if (run_inc == RUN_LOCK) state_next = LOCKED;
                    end else begin
                        run_next = '0;
                    end
                end
                LOCKED: begin
                    if (step_ok) begin
                        wrap_next = step_wrap;
                    end else begin
`ifdef COUNTER_MONITOR_RESET_TOLERANT_EN
                        // A non-wrapping return to zero is an upstream counter reset.
                        if (count_in == '0) begin
                            state_next = SYNC;
                            run_next   = '0;
                        end else begin
                            fault      = 1'b1;
                            state_next = FAULT;
                        end
`else
                        fault      = 1'b1;
                        state_next = FAULT;
`endif
                    end
                end
                FAULT: begin
                    run_next   = '0;
                    state_next = SYNC;
                end
                default: state_next = ACQUIRE;
            endcase
        end

        if (wrap_next && (wrap_count != STAT_MAX)) wrap_count_next = wrap_count + STAT_ONE;

        // A fault on the same edge as a clear restarts the error count at one.
        if (fault) begin
            seq_err_next = 1'b1;
            if (clear_err)                  err_count_next = STAT_ONE;
            else if (err_count != STAT_MAX) err_count_next = err_count + STAT_ONE;
        end else if (clear_err) begin
            seq_err_next   = 1'b0;
            err_count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ACQUIRE;
            prev        <= '0;
            run         <= '0;
            match_pulse <= 1'b0;
            wrap_pulse  <= 1'b0;
            seq_err     <= 1'b0;
            wrap_count  <= '0;
            err_count   <= '0;
        end else begin
            state       <= state_next;
            prev        <= prev_next;
            run         <= run_next;
            match_pulse <= match_next;
            wrap_pulse  <= wrap_next;
            seq_err     <= seq_err_next;
            wrap_count  <= wrap_count_next;
            err_count   <= err_count_next;
        end
    end

endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Downstream consumer of the 8-bit free-running up-counter's `result` bus.
- Samples the count value and checks that each new sample is exactly the previous one plus one, with wrap from max to 0.
- Reports wrap events, compare-match events, and sequence faults, and keeps sticky error status and saturating statistics for the test harness.
- Sits in the same clock domain as the counter, with the counter output wired straight to `count_in`.

Parameters:
- WIDTH, 8, width of the monitored count bus.
- STAT_WIDTH, 8, width of `wrap_count` and `err_count`; both saturate at 2^STAT_WIDTH-1.
- LOCK_LEN, 4, number of consecutive correct increments needed to enter LOCKED; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  count value under observation.
- count_valid  input  1  count_in is sampled this cycle.
- match_value  input  WIDTH  compare value for match_pulse.
- clear_err  input  1  one-cycle request to clear seq_err and err_count.
- locked  output  1  high while the FSM is in LOCKED.
- match_pulse  output  1  one-cycle pulse: the sampled value equalled match_value.
- wrap_pulse  output  1  one-cycle pulse: a correct max->0 step was seen.
- seq_err  output  1  sticky fault flag.
- wrap_count  output  STAT_WIDTH  saturating count of correct wraps.
- err_count  output  STAT_WIDTH  saturating count of faults.

Behaviour:
- Reset: one clock, one reset; reset is synchronous and active-high.
  - Asserting reset at a rising edge sets all outputs to 0, state to ACQUIRE, prev to 0 and run to 0.
  - Reset overrides every other input, including mid-operation.
- Outputs: all registered. A sample taken at edge N is reflected in the outputs after edge N (1-cycle latency). Pulses last exactly one cycle.
- Valid gating: when count_valid=0, state, prev, run and the statistics hold, and both pulses are 0.
- Step definitions, for a valid sample s:
  - Correct step: s == (prev+1) mod 2^WIDTH.
  - Wrap: a correct step where prev == 2^WIDTH-1.
- FSM states:
  - ACQUIRE: first valid sample -> prev=s, run=0, go to SYNC. No check is made and no error is possible.
  - SYNC:
    - Correct step -> run++. When run reaches LOCK_LEN, go to LOCKED.
    - Incorrect step -> run=0, stay in SYNC, no error.
    - prev=s on every valid sample.
  - LOCKED:
    - Correct step -> stay.
    - Incorrect step -> go to FAULT, seq_err=1, err_count++ (saturating).
    - prev=s.
  - FAULT: next valid sample -> prev=s (new baseline), run=0, go to SYNC. That sample is not checked.
- wrap_pulse and wrap_count: update on a wrap in SYNC or LOCKED only.
- match_pulse: asserted for any valid sample with s==match_value, in every state including ACQUIRE.
- clear_err: sets seq_err=0 and err_count=0 on the next edge.
  - If a fault is detected on the same edge, the fault wins: seq_err=1, err_count=1.
  - clear_err does not change FSM state or wrap_count.
- Saturation: at all-ones, both counters hold their value with no rollover.
- Arithmetic: all comparisons are done modulo 2^WIDTH, using unsigned WIDTH-bit add.

Optional Feature:
- Macro: COUNTER_MONITOR_RESET_TOLERANT_EN.
- Defined: in LOCKED, a sample s==0 with prev != 2^WIDTH-1 is treated as an upstream counter reset.
  - FSM goes to SYNC with prev=0 and run=0.
  - No seq_err, no err_count change, no wrap_pulse.
- Not defined: that sample is an ordinary incorrect step, so LOCKED goes to FAULT with an error.

Test Plan:
- Locking: reset, then count_valid=1 with count_in 0,1,2,3,4 on consecutive cycles (LOCK_LEN=4) -> locked rises 1 cycle after the sample 4 edge. seq_err=0.
- Wrap: locked, feed 254,255,0,1 -> wrap_pulse=1 for one cycle after the 0 sample; wrap_count=1; no error.
- Fault and recovery: locked at 10, feed 12 -> seq_err=1, err_count=1, locked=0 (FAULT). Then feed 20,21,22,23,24 -> locked=1 again; seq_err stays 1.
- Clear vs fault: locked at 50, feed 52 with clear_err=1 on the same cycle -> seq_err=1, err_count=1. Then clear_err alone -> seq_err=0, err_count=0.
- Saturation, match and gating:
  - 255 forced faults (STAT_WIDTH=8), plus one more -> err_count holds 255.
  - match_value=7 and sample 7 -> match_pulse=1.
  - count_valid=0 for 3 cycles mid-run -> no state change and no error on resume.
- Optional feature: with COUNTER_MONITOR_RESET_TOLERANT_EN defined, locked at 100, feed 0 -> locked=0, seq_err=0, err_count=0, state SYNC. Without the macro -> seq_err=1, err_count=1.
